// File: rtl/debug_spi_tracer.sv
// Multi-channel debug trace serializer: captures parallel debug words into a
// snapshot FIFO and shifts each snapshot out as a mode-0 SPI frame per channel.
module debug_spi_tracer #(
   parameter int CHANNELS  = 4,
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int DIV       = 4,
   parameter int GAP       = 2,
   parameter int LSB_FIRST = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         capture,
   input  logic [CHANNELS*WIDTH-1:0]    ch_data,
   input  logic [CHANNELS-1:0]          ch_en,
   output logic                         spi_sck,
   output logic [CHANNELS-1:0]          spi_cs_n,
   output logic [CHANNELS-1:0]          spi_mosi,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
   output logic [15:0]                  overflow_cnt
);

   localparam int LVL_W   = $clog2(DEPTH + 1);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int BIT_W   = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   // Snapshot FIFO
   logic [CHANNELS*WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]          wr_ptr_reg;
   logic [PTR_W-1:0]          rd_ptr_reg;
   logic [LVL_W-1:0]          level_reg;
   logic [LVL_W-1:0]          level_next;
   logic [15:0]               ovf_reg;
   logic                      pop;
   logic                      push;
   logic                      drop;

   // Frame engine
   state_t                          state_reg, state_next;
   logic [CNT_W-1:0]                cnt_reg, cnt_next;
   logic                            phase_reg, phase_next;
   logic [BIT_W-1:0]                bit_reg, bit_next;
   logic [CHANNELS-1:0][WIDTH-1:0]  shift_reg, shift_next;
   logic [CHANNELS-1:0][WIDTH-1:0]  shifted;
   logic [CHANNELS-1:0]             en_reg, en_next;
   logic [CHANNELS-1:0]             head_bit;
   logic                            frame_active;

   // Registered outputs
   logic                sck_reg, sck_next;
   logic [CHANNELS-1:0] cs_n_reg, cs_n_next;
   logic [CHANNELS-1:0] mosi_reg, mosi_next;
   logic                busy_reg, busy_next;

   // A full FIFO still accepts a capture when the engine pops in the same cycle.
   assign pop  = (state_reg == ST_IDLE) && (level_reg != '0);
   assign push = capture && ((level_reg != LVL_W'(DEPTH)) || pop);
   assign drop = capture && !push;

   always_comb begin
      level_next = level_reg;
      unique case ({push, pop})
         2'b10:   level_next = level_reg + LVL_W'(1);
         2'b01:   level_next = level_reg - LVL_W'(1);
         default: level_next = level_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         ovf_reg    <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         level_reg <= level_next;
         if (drop && (ovf_reg != 16'hFFFF)) ovf_reg <= ovf_reg + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= ch_data;
   end

   // Per-channel shift and the bit that will be on MOSI after the update.
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         if (LSB_FIRST != 0) begin : g_lsb
            assign shifted[gi]  = {1'b0, shift_reg[gi][WIDTH-1:1]};
            assign head_bit[gi] = shift_next[gi][0];
         end else begin : g_msb
            assign shifted[gi]  = {shift_reg[gi][WIDTH-2:0], 1'b0};
            assign head_bit[gi] = shift_next[gi][WIDTH-1];
         end
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      phase_next = phase_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      en_next    = en_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (pop) begin
               state_next = ST_SHIFT;
               cnt_next   = '0;
               phase_next = 1'b0;
               bit_next   = '0;
               shift_next = mem[rd_ptr_reg];
               en_next    = ch_en;
            end
         end
         ST_SHIFT: begin
            if (cnt_reg == CNT_W'(DIV - 1)) begin
               cnt_next = '0;
               if (!phase_reg) begin
                  phase_next = 1'b1;
               end else begin
                  phase_next = 1'b0;
                  // The last bit is not shifted away so HOLD keeps it on MOSI.
                  if (bit_reg == BIT_W'(WIDTH - 1)) begin
                     state_next = ST_HOLD;
                  end else begin
                     bit_next   = bit_reg + BIT_W'(1);
                     shift_next = shifted;
                  end
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_reg == CNT_W'(DIV - 1)) begin
               state_next = ST_GAP;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt_reg == CNT_W'(GAP - 1)) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Outputs are derived from the next state so they register in step with it.
      frame_active = (state_next == ST_SHIFT) || (state_next == ST_HOLD);
      sck_next     = (state_next == ST_SHIFT) && phase_next;
      cs_n_next    = frame_active ? ~en_next : '1;
      mosi_next    = frame_active ? (head_bit & en_next) : '0;
      busy_next    = (state_next != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         phase_reg <= 1'b0;
         bit_reg   <= '0;
         shift_reg <= '0;
         en_reg    <= '0;
         sck_reg   <= 1'b0;
         cs_n_reg  <= '1;
         mosi_reg  <= '0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         phase_reg <= phase_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         en_reg    <= en_next;
         sck_reg   <= sck_next;
         cs_n_reg  <= cs_n_next;
         mosi_reg  <= mosi_next;
         busy_reg  <= busy_next;
      end
   end

   assign spi_sck      = sck_reg;
   assign spi_cs_n     = cs_n_reg;
   assign spi_mosi     = mosi_reg;
   assign busy         = busy_reg;
   assign fifo_level   = level_reg;
   assign overflow_cnt = ovf_reg;

endmodule

// File: tb/tb_debug_spi_tracer.sv
// Directed bench for debug_spi_tracer: an MSB-first and an LSB-first instance
// share stimulus; monitors decode frames, one initial block drives and checks.
module tb_debug_spi_tracer;

   logic        clk;
   logic        rst_n;
   logic        capture;
   logic [31:0] ch_data;
   logic [3:0]  ch_en;

   logic        sck_m, sck_l;
   logic [3:0]  cs_m, cs_l, mosi_m, mosi_l;
   logic        busy_m, busy_l;
   logic [2:0]  lvl_m, lvl_l;
   logic [15:0] ovf_m, ovf_l;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int              start;
      int              len;
      logic [3:0]      cs;
      logic [3:0][7:0] data;
      int              bits;
      logic            junk;
   } frame_t;

   frame_t q_m[$];
   frame_t q_l[$];

   debug_spi_tracer #(.CHANNELS(4), .WIDTH(8), .DEPTH(4), .DIV(2), .GAP(2), .LSB_FIRST(0)) dut (
      .clk(clk), .rst_n(rst_n), .capture(capture), .ch_data(ch_data), .ch_en(ch_en),
      .spi_sck(sck_m), .spi_cs_n(cs_m), .spi_mosi(mosi_m), .busy(busy_m),
      .fifo_level(lvl_m), .overflow_cnt(ovf_m)
   );

   debug_spi_tracer #(.CHANNELS(4), .WIDTH(8), .DEPTH(4), .DIV(2), .GAP(2), .LSB_FIRST(1)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .capture(capture), .ch_data(ch_data), .ch_en(ch_en),
      .spi_sck(sck_l), .spi_cs_n(cs_l), .spi_mosi(mosi_l), .busy(busy_l),
      .fifo_level(lvl_l), .overflow_cnt(ovf_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Frame decoders: first received bit lands in the MSB of the collected word.
   initial begin : mon_m
      frame_t cur;
      logic   in_f;
      logic   prev;
      in_f = 1'b0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_f = 1'b0;
            prev = 1'b0;
         end else begin
            if (!in_f && cs_m != 4'hF) begin
               in_f = 1'b1; cur.start = cyc; cur.len = 0; cur.cs = cs_m;
               cur.data = '0; cur.bits = 0; cur.junk = 1'b0;
            end
            if (in_f) begin
               if (cs_m == 4'hF) begin
                  q_m.push_back(cur);
                  in_f = 1'b0;
               end else begin
                  cur.len++;
                  if (sck_m && !prev) begin
                     for (int k = 0; k < 4; k++) cur.data[k] = {cur.data[k][6:0], mosi_m[k]};
                     cur.bits++;
                  end
                  cur.junk = cur.junk | (|(mosi_m & cur.cs));
               end
            end
            prev = sck_m;
         end
      end
   end

   initial begin : mon_l
      frame_t cur;
      logic   in_f;
      logic   prev;
      in_f = 1'b0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_f = 1'b0;
            prev = 1'b0;
         end else begin
            if (!in_f && cs_l != 4'hF) begin
               in_f = 1'b1; cur.start = cyc; cur.len = 0; cur.cs = cs_l;
               cur.data = '0; cur.bits = 0; cur.junk = 1'b0;
            end
            if (in_f) begin
               if (cs_l == 4'hF) begin
                  q_l.push_back(cur);
                  in_f = 1'b0;
               end else begin
                  cur.len++;
                  if (sck_l && !prev) begin
                     for (int k = 0; k < 4; k++) cur.data[k] = {cur.data[k][6:0], mosi_l[k]};
                     cur.bits++;
                  end
                  cur.junk = cur.junk | (|(mosi_l & cur.cs));
               end
            end
            prev = sck_l;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_frames(input int n, input int limit);
      int k;
      k = 0;
      while (q_m.size() < n && k < limit) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      check("frame_timeout", (q_m.size() >= n) && (q_l.size() >= n), 1'b1);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((busy_m || busy_l) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", busy_m | busy_l, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   int t0;

   initial begin
      rst_n   = 1'b1;
      capture = 1'b0;
      ch_data = '0;
      ch_en   = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_sck",  sck_m, 1'b0);
      check("rst_cs",   cs_m, 4'hF);
      check("rst_mosi", mosi_m, 4'h0);
      check("rst_busy", busy_m, 1'b0);
      check("rst_lvl",  lvl_m, 3'd0);
      check("rst_ovf",  ovf_m, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_busy",   busy_m, 1'b0);
      check("idle_cs",     cs_m, 4'hF);
      check("idle_frames", q_m.size(), 0);

      // Single capture, channel 0 only; inputs change mid-frame
      q_m.delete(); q_l.delete();
      ch_data = {8'h3C, 8'hC3, 8'h5A, 8'hA5};
      ch_en   = 4'b0001;
      capture = 1'b1;
      t0      = cyc;
      @(negedge clk);
      capture = 1'b0;
      ch_data = 32'h0000_0000;
      check("single_lvl_t1", lvl_m, 3'd1);
      @(negedge clk);
      ch_en = 4'b1111;
      check("single_lvl_t2",  lvl_m, 3'd0);
      check("single_busy_t2", busy_m, 1'b1);
      check("single_cs_t2",   cs_m, 4'b1110);
      wait_frames(1, 100);
      check("single_start", q_m[0].start - t0, 2);
      check("single_len",   q_m[0].len, 34);
      check("single_csp",   q_m[0].cs, 4'b1110);
      check("single_ch0",   q_m[0].data[0], 8'hA5);
      check("single_other", q_m[0].data[3:1], 24'h0);
      check("single_bits",  q_m[0].bits, 8);
      check("single_junk",  q_m[0].junk, 1'b0);
      check("lsb_single_ch0",   q_l[0].data[0], 8'hA5);
      check("lsb_single_start", q_l[0].start - t0, 2);
      wait_idle();

      // All channels enabled
      q_m.delete(); q_l.delete();
      ch_data = {8'h00, 8'hFF, 8'h80, 8'h01};
      ch_en   = 4'b1111;
      capture = 1'b1;
      @(negedge clk);
      capture = 1'b0;
      wait_frames(1, 100);
      check("all_cs",       q_m[0].cs, 4'b0000);
      check("all_data",     q_m[0].data, 32'h00FF_8001);
      check("all_len",      q_m[0].len, 34);
      check("lsb_all_data", q_l[0].data, 32'h00FF_0180);
      wait_idle();

      // Channels 0 and 2 only; ch_en changes after the pop
      q_m.delete(); q_l.delete();
      ch_en   = 4'b0101;
      capture = 1'b1;
      @(negedge clk);
      capture = 1'b0;
      @(negedge clk);
      ch_en = 4'b1111;
      wait_frames(1, 100);
      check("en5_cs",       q_m[0].cs, 4'b1010);
      check("en5_data",     q_m[0].data, 32'h00FF_0001);
      check("en5_junk",     q_m[0].junk, 1'b0);
      check("lsb_en5_data", q_l[0].data, 32'h00FF_0080);
      wait_idle();

      // Overflow: six back-to-back captures
      q_m.delete(); q_l.delete();
      ch_en   = 4'b0001;
      ch_data = 32'h0000_0010;
      capture = 1'b1;
      t0      = cyc;
      for (int i = 1; i < 6; i++) begin
         @(negedge clk);
         ch_data = 32'h0000_0010 + i;
      end
      @(negedge clk);
      capture = 1'b0;
      check("ovf_cnt", ovf_m, 16'd1);
      check("ovf_lvl", lvl_m, 3'd4);
      wait_frames(5, 400);
      repeat (60) @(negedge clk);
      check("ovf_nframes", q_m.size(), 5);
      check("ovf_start",   q_m[0].start - t0, 2);
      for (int i = 0; i < 5; i++) check($sformatf("ovf_data%0d", i), q_m[i].data[0], 8'h10 + i);
      for (int i = 1; i < 5; i++) check($sformatf("ovf_period%0d", i), q_m[i].start - q_m[i-1].start, 37);
      wait_idle();

      // Full FIFO with a capture in the pop cycle
      q_m.delete(); q_l.delete();
      ch_data = 32'h0000_0020;
      capture = 1'b1;
      t0      = cyc;
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         ch_data = 32'h0000_0020 + i;
      end
      @(negedge clk);
      capture = 1'b0;
      while (cyc < t0 + 38) @(negedge clk);
      check("full_lvl_pre",  lvl_m, 3'd4);
      check("full_busy_pre", busy_m, 1'b0);
      ch_data = 32'h0000_005A;
      capture = 1'b1;
      @(negedge clk);
      capture = 1'b0;
      check("full_lvl_post", lvl_m, 3'd4);
      check("full_ovf_post", ovf_m, 16'd1);
      wait_frames(6, 400);
      repeat (60) @(negedge clk);
      check("full_nframes", q_m.size(), 6);
      check("full_data4",   q_m[4].data[0], 8'h24);
      check("full_data5",   q_m[5].data[0], 8'h5A);
      wait_idle();

      // Asynchronous reset in the middle of a frame
      q_m.delete(); q_l.delete();
      ch_data = 32'h0000_00F7;
      capture = 1'b1;
      t0      = cyc;
      @(negedge clk);
      @(negedge clk);
      capture = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_sck_pre",  sck_m, 1'b1);
      check("mid_mosi_pre", mosi_m, 4'b0001);
      check("mid_cs_pre",   cs_m, 4'b1110);
      check("mid_lvl_pre",  lvl_m, 3'd1);
      check("mid_ovf_pre",  ovf_m, 16'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sck",  sck_m, 1'b0);
      check("mid_rst_cs",   cs_m, 4'hF);
      check("mid_rst_mosi", mosi_m, 4'h0);
      check("mid_rst_busy", busy_m, 1'b0);
      check("mid_rst_lvl",  lvl_m, 3'd0);
      check("mid_rst_ovf",  ovf_m, 16'd0);
      check("mid_rst_cs_l", cs_l, 4'hF);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q_m.delete(); q_l.delete();
      repeat (80) @(negedge clk);
      check("post_rst_frames", q_m.size(), 0);
      check("post_rst_busy",   busy_m, 1'b0);
      check("post_rst_cs",     cs_m, 4'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
